// File: rtl/md5_nonce_scheduler.sv
`timescale 1ns/1ps
// md5_nonce_scheduler: brute-force nonce sequencer for an MD5 engine pool.
// Builds padded single-block messages (key || decimal nonce), streams them
// over a valid/ready handshake, tracks the smallest matching nonce reported
// back, drains in-flight engines after the first match and reports it.
// Ports:
//   clk_i, reset_ni            clock, synchronous active-low reset
//   start_i, key_data_i/len_i  search start and key (sampled on start)
//   busy_o, done_o, found_o    status; done_o pulses with answer_o valid
//   answer_o                   smallest match, or all-ones if none
//   md5_block_*                block stream to the engine pool
//   result_valid_i/nonce_i     match reports from the engine pool
module md5_nonce_scheduler #(
   parameter int     KEY_BYTES    = 8,
   parameter int     MAX_DIGITS   = 10,
   parameter int     NONCE_WIDTH  = 34,
   parameter longint START_NONCE  = 1,
   parameter int     DRAIN_CYCLES = 512
) (
   input  logic                           clk_i,
   input  logic                           reset_ni,
   input  logic                           start_i,
   input  logic [8*KEY_BYTES-1:0]         key_data_i,
   input  logic [$clog2(KEY_BYTES+1)-1:0] key_len_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           found_o,
   output logic [NONCE_WIDTH-1:0]         answer_o,
   input  logic                           md5_block_ready_i,
   output logic                           md5_block_valid_o,
   output logic [511:0]                   md5_block_data_o,
   output logic [NONCE_WIDTH-1:0]         md5_block_nonce_o,
   input  logic                           result_valid_i,
   input  logic [NONCE_WIDTH-1:0]         result_nonce_i
);

   localparam int KLW = $clog2(KEY_BYTES+1);
   localparam int DW  = $clog2(MAX_DIGITS+1);
   localparam int BW  = 4*MAX_DIGITS;
   localparam int TW  = $clog2(DRAIN_CYCLES+1);

   function automatic longint unsigned pow10(int n);
      longint unsigned r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [BW-1:0] to_bcd(longint unsigned v);
      logic [BW-1:0] r = '0;
      for (int d = 0; d < MAX_DIGITS; d++) begin
         r[4*d+:4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] num_digits(longint unsigned v);
      int n = 1;
      for (int d = 1; d < MAX_DIGITS; d++)
         if (v >= pow10(d)) n = d + 1;
      return DW'(n);
   endfunction

   localparam logic [NONCE_WIDTH-1:0] FIRST    = NONCE_WIDTH'(START_NONCE);
   localparam logic [NONCE_WIDTH-1:0] LAST     = NONCE_WIDTH'(pow10(MAX_DIGITS) - 1);
   localparam logic [BW-1:0]          FIRST_BCD = to_bcd(START_NONCE);
   localparam logic [DW-1:0]          FIRST_ND  = num_digits(START_NONCE);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_e;

   state_e                 state_q;
   logic [8*KEY_BYTES-1:0] key_q;
   logic [KLW-1:0]         klen_q;
   logic [NONCE_WIDTH-1:0] nonce_q, bnonce_q, best_q, best_d, answer_q;
   logic [BW-1:0]          bcd_q, bcd_d;
   logic [DW-1:0]          ndig_q, ndig_d;
   logic [511:0]           blk_q, blk_d;
   logic [TW-1:0]          timer_q;
   logic                   vld_q, busy_q, done_q, found_q, hit_q, hit_d;
   logic                   carry;
   int                     kl, nd;

   // Decimal increment kept alongside the binary nonce; ndig grows when the
   // carry lands on a digit above the current most significant one.
   always_comb begin
      bcd_d  = bcd_q;
      ndig_d = ndig_q;
      carry  = 1'b1;
      for (int d = 0; d < MAX_DIGITS; d++) begin
         if (carry) begin
            if (bcd_d[4*d+:4] == 4'd9) begin
               bcd_d[4*d+:4] = 4'd0;
            end else begin
               bcd_d[4*d+:4] = bcd_d[4*d+:4] + 4'd1;
               carry = 1'b0;
               if (DW'(d) >= ndig_q) ndig_d = DW'(d + 1);
            end
         end
      end
   end

   // Message block for the current nonce: key, digits (MSD first), 0x80,
   // zero fill, 64-bit little-endian bit length in bytes 56..63.
   always_comb begin
      kl    = int'(klen_q);
      nd    = int'(ndig_q);
      blk_d = '0;
      for (int k = 0; k < KEY_BYTES; k++)
         if (k < kl) blk_d[8*k+:8] = key_q[8*k+:8];
      for (int j = 0; j < MAX_DIGITS; j++)
         if (j < nd) blk_d[8*(kl+j)+:8] = {4'h3, bcd_q[4*(nd-1-j)+:4]};
      blk_d[8*(kl+nd)+:8] = 8'h80;
      blk_d[511:448]      = 64'(8 * (kl + nd));
   end

   // Results count only while a search is issuing or draining.
   always_comb begin
      best_d = best_q;
      hit_d  = hit_q;
      if (result_valid_i && (state_q == S_ISSUE || state_q == S_DRAIN)) begin
         if (!hit_q || result_nonce_i < best_q) best_d = result_nonce_i;
         hit_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q  <= S_IDLE;
         key_q    <= '0;
         klen_q   <= '0;
         nonce_q  <= '0;
         bnonce_q <= '0;
         bcd_q    <= '0;
         ndig_q   <= '0;
         blk_q    <= '0;
         best_q   <= '0;
         hit_q    <= 1'b0;
         answer_q <= '0;
         found_q  <= 1'b0;
         timer_q  <= '0;
         vld_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         best_q <= best_d;
         hit_q  <= hit_d;
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  key_q   <= key_data_i;
                  klen_q  <= key_len_i;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               nonce_q <= FIRST;
               bcd_q   <= FIRST_BCD;
               ndig_q  <= FIRST_ND;
               hit_q   <= 1'b0;
               vld_q   <= 1'b0;
               state_q <= S_ISSUE;
            end
            S_ISSUE: begin
               if (vld_q && md5_block_ready_i) begin
                  vld_q   <= 1'b0;
                  nonce_q <= nonce_q + NONCE_WIDTH'(1);
                  bcd_q   <= bcd_d;
                  ndig_q  <= ndig_d;
                  if (nonce_q == LAST) begin
                     state_q <= S_DRAIN;
                     timer_q <= TW'(DRAIN_CYCLES);
                  end
               end else if (!vld_q) begin
                  blk_q    <= blk_d;
                  bnonce_q <= nonce_q;
                  vld_q    <= 1'b1;
               end
               // Withdrawing an unaccepted block is safe: the pool only
               // rotates its selector on a completed handshake.
               if (result_valid_i) begin
                  vld_q   <= 1'b0;
                  state_q <= S_DRAIN;
                  timer_q <= TW'(DRAIN_CYCLES);
               end
            end
            S_DRAIN: begin
               if (timer_q == '0) begin
                  state_q  <= S_DONE;
                  done_q   <= 1'b1;
                  found_q  <= hit_d;
                  answer_q <= hit_d ? best_d : '1;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o            = busy_q;
   assign done_o            = done_q;
   assign found_o           = found_q;
   assign answer_o          = answer_q;
   assign md5_block_valid_o = vld_q;
   assign md5_block_data_o  = blk_q;
   assign md5_block_nonce_o = bnonce_q;

endmodule

// File: tb/tb_md5_nonce_scheduler.sv
`timescale 1ns/1ps
// Testbench for md5_nonce_scheduler: two instances, one wide search
// starting near a known answer, one two-digit instance run to exhaustion.
module tb_md5_nonce_scheduler;

   localparam longint A_START = 609000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic         a_reset_n, a_start, a_busy, a_done, a_found;
   logic [63:0]  a_key;
   logic [3:0]   a_klen;
   logic [33:0]  a_answer, a_nonce, a_rn;
   logic         a_ready, a_valid, a_rv;
   logic [511:0] a_data;

   logic         b_reset_n, b_start, b_busy, b_done, b_found;
   logic [63:0]  b_key;
   logic [3:0]   b_klen;
   logic [6:0]   b_answer, b_nonce, b_rn;
   logic         b_ready, b_valid, b_rv;
   logic [511:0] b_data;

   md5_nonce_scheduler #(
      .KEY_BYTES(8), .MAX_DIGITS(10), .NONCE_WIDTH(34),
      .START_NONCE(A_START), .DRAIN_CYCLES(128)
   ) dut_a (
      .clk_i(clk), .reset_ni(a_reset_n), .start_i(a_start),
      .key_data_i(a_key), .key_len_i(a_klen),
      .busy_o(a_busy), .done_o(a_done), .found_o(a_found),
      .answer_o(a_answer),
      .md5_block_ready_i(a_ready), .md5_block_valid_o(a_valid),
      .md5_block_data_o(a_data), .md5_block_nonce_o(a_nonce),
      .result_valid_i(a_rv), .result_nonce_i(a_rn)
   );

   md5_nonce_scheduler #(
      .KEY_BYTES(8), .MAX_DIGITS(2), .NONCE_WIDTH(7),
      .START_NONCE(1), .DRAIN_CYCLES(16)
   ) dut_b (
      .clk_i(clk), .reset_ni(b_reset_n), .start_i(b_start),
      .key_data_i(b_key), .key_len_i(b_klen),
      .busy_o(b_busy), .done_o(b_done), .found_o(b_found),
      .answer_o(b_answer),
      .md5_block_ready_i(b_ready), .md5_block_valid_o(b_valid),
      .md5_block_data_o(b_data), .md5_block_nonce_o(b_nonce),
      .result_valid_i(b_rv), .result_nonce_i(b_rn)
   );

   function automatic logic [63:0] pack_key(string s);
      logic [63:0] k = '0;
      for (int i = 0; i < s.len(); i++) k[8*i+:8] = s[i];
      return k;
   endfunction

   // Reference: MD5 padding of the string key||decimal(nonce).
   function automatic logic [511:0] model_block(string key, longint nonce);
      string m = {key, $sformatf("%0d", nonce)};
      logic [511:0] b = '0;
      for (int i = 0; i < m.len(); i++) b[8*i+:8] = m[i];
      b[8*m.len()+:8] = 8'h80;
      b[511:448] = 64'(8 * m.len());
      return b;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_a(string key);
      a_key   = pack_key(key);
      a_klen  = 4'(key.len());
      a_start = 1'b1;
      tick;
      a_start = 1'b0;
   endtask

   task automatic test_reset;
      a_reset_n = 1'b0;
      b_reset_n = 1'b0;
      tick;
      tick;
      checks++;
      if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
      checks++;
      if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", a_done); end
      checks++;
      if (a_found !== 1'b0) begin errors++; $display("FAIL reset_found: got %b want 0", a_found); end
      checks++;
      if (a_answer !== 34'd0) begin errors++; $display("FAIL reset_answer: got %0d want 0", a_answer); end
      checks++;
      if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b/%b want 0/0", a_valid, b_valid);
      end
      a_reset_n = 1'b1;
      b_reset_n = 1'b1;
      tick;
   endtask

   task automatic test_search;
      longint exp_n = A_START;
      int due = -1;
      int cyc = 0;
      bit stopped = 1'b0;
      bit got = 1'b0;
      start_a("abcdef");
      while (!got && cyc < 3000) begin
         if (a_done === 1'b1) begin
            got = 1'b1;
         end else begin
            if (stopped) begin
               checks++;
               if (a_valid !== 1'b0) begin
                  errors++; $display("FAIL search_stop: valid=%b want 0", a_valid);
               end
            end
            a_ready = stopped ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (a_valid === 1'b1 && a_ready) begin
               checks++;
               if (a_nonce !== 34'(exp_n)) begin
                  errors++; $display("FAIL search_nonce: got %0d want %0d", a_nonce, exp_n);
               end
               checks++;
               if (a_data !== model_block("abcdef", exp_n)) begin
                  errors++; $display("FAIL search_block: got %h want %h", a_data, model_block("abcdef", exp_n));
               end
               if (exp_n == 609043) due = cyc + 64;
               exp_n++;
            end
            a_rv = (cyc == due);
            a_rn = 34'd609043;
            if (a_rv) stopped = 1'b1;
            tick;
            cyc++;
         end
      end
      a_rv    = 1'b0;
      a_ready = 1'b0;
      checks++;
      if (!got) begin errors++; $display("FAIL search_timeout: done=%b want 1", a_done); end
      checks++;
      if (a_found !== 1'b1) begin errors++; $display("FAIL search_found: got %b want 1", a_found); end
      checks++;
      if (a_answer !== 34'd609043) begin errors++; $display("FAIL search_answer: got %0d want 609043", a_answer); end
      checks++;
      if (a_busy !== 1'b1) begin errors++; $display("FAIL search_busy_done: got %b want 1", a_busy); end
      tick;
      checks++;
      if (a_busy !== 1'b0 || a_done !== 1'b0) begin
         errors++; $display("FAIL search_idle: busy=%b done=%b want 0 0", a_busy, a_done);
      end
   endtask

   task automatic test_best_tracking;
      longint exp_min = -1;
      longint v;
      int cyc = 0;
      bit got = 1'b0;
      start_a("xyz");
      a_ready = 1'b1;
      while (!got && cyc < 1000) begin
         if (a_done === 1'b1) begin
            got = 1'b1;
         end else begin
            a_rv = 1'b0;
            v = 0;
            if (cyc == 6) v = 1200;
            else if (cyc == 12) v = 1100;
            else if (cyc >= 20 && cyc <= 80 && $urandom_range(0, 7) == 0)
               v = longint'($urandom_range(1101, 3000));
            if (v != 0) begin
               a_rv = 1'b1;
               a_rn = 34'(v);
               if (exp_min < 0 || v < exp_min) exp_min = v;
            end
            tick;
            cyc++;
         end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL best_timeout: done=%b want 1", a_done); end
      checks++;
      if (a_answer !== 34'(exp_min)) begin
         errors++; $display("FAIL best_answer: got %0d want %0d", a_answer, exp_min);
      end
      checks++;
      if (a_found !== 1'b1) begin errors++; $display("FAIL best_found: got %b want 1", a_found); end
      a_rv = 1'b1;
      a_rn = 34'd1000;
      tick;
      a_rn = 34'd5;
      tick;
      a_rv = 1'b0;
      tick;
      checks++;
      if (a_answer !== 34'(exp_min) || a_found !== 1'b1) begin
         errors++; $display("FAIL best_late_result: got %0d/%b want %0d/1", a_answer, a_found, exp_min);
      end
      checks++;
      if (a_done !== 1'b0 || a_busy !== 1'b0) begin
         errors++; $display("FAIL best_late_state: done=%b busy=%b want 0 0", a_done, a_busy);
      end
      a_ready = 1'b0;
   endtask

   task automatic wait_a_valid(string name);
      int n = 0;
      while (a_valid !== 1'b1 && n < 10) begin tick; n++; end
      checks++;
      if (a_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, a_valid); end
   endtask

   task automatic test_backpressure_and_reset;
      a_ready = 1'b0;
      start_a("k");
      wait_a_valid("hold");
      for (int i = 0; i < 20; i++) begin
         // A start while busy must not disturb the running search.
         if (i == 5) begin
            a_key = pack_key("zz"); a_klen = 4'd2; a_start = 1'b1;
         end else begin
            a_start = 1'b0;
         end
         checks++;
         if (a_valid !== 1'b1 || a_nonce !== 34'(A_START) || a_data !== model_block("k", A_START)) begin
            errors++;
            $display("FAIL hold_stable: valid=%b nonce=%0d want 1 %0d", a_valid, a_nonce, A_START);
         end
         tick;
      end
      a_start = 1'b0;
      a_ready = 1'b1;
      tick;
      a_ready = 1'b0;
      wait_a_valid("release");
      checks++;
      if (a_nonce !== 34'(A_START + 1) || a_data !== model_block("k", A_START + 1)) begin
         errors++; $display("FAIL release_next: nonce=%0d want %0d", a_nonce, A_START + 1);
      end
      a_reset_n = 1'b0;
      tick;
      checks++;
      if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
         errors++; $display("FAIL midreset: valid=%b busy=%b want 0 0", a_valid, a_busy);
      end
      a_reset_n = 1'b1;
      tick;
      start_a("k");
      wait_a_valid("restart");
      checks++;
      if (a_nonce !== 34'(A_START) || a_data !== model_block("k", A_START)) begin
         errors++; $display("FAIL restart_nonce: got %0d want %0d", a_nonce, A_START);
      end
      a_reset_n = 1'b0;
      tick;
      a_reset_n = 1'b1;
      tick;
   endtask

   task automatic test_exhaust;
      int exp_n = 1;
      int count = 0;
      int cyc = 0;
      bit got = 1'b0;
      b_key   = pack_key("abc");
      b_klen  = 4'd3;
      b_start = 1'b1;
      tick;
      b_start = 1'b0;
      while (!got && cyc < 1500) begin
         if (b_done === 1'b1) begin
            got = 1'b1;
         end else begin
            if (count == 99) begin
               checks++;
               if (b_valid !== 1'b0) begin
                  errors++; $display("FAIL exhaust_stop: valid=%b nonce=%0d want 0", b_valid, b_nonce);
               end
            end
            b_ready = ($urandom_range(0, 2) != 0);
            if (b_valid === 1'b1 && b_ready) begin
               checks++;
               if (b_nonce !== 7'(exp_n)) begin
                  errors++; $display("FAIL exhaust_nonce: got %0d want %0d", b_nonce, exp_n);
               end
               checks++;
               if (b_data !== model_block("abc", longint'(exp_n))) begin
                  errors++; $display("FAIL exhaust_block: got %h want %h", b_data, model_block("abc", longint'(exp_n)));
               end
               if (exp_n == 10) begin
                  checks++;
                  if (b_data[39:24] !== 16'h3031 || b_data[47:40] !== 8'h80 || b_data[511:448] !== 64'd40) begin
                     errors++; $display("FAIL digit_rollover: got %h %h %0d want 3031 80 40", b_data[39:24], b_data[47:40], b_data[511:448]);
                  end
               end
               exp_n++;
               count++;
            end
            tick;
            cyc++;
         end
      end
      b_ready = 1'b0;
      checks++;
      if (!got) begin errors++; $display("FAIL exhaust_timeout: done=%b want 1", b_done); end
      checks++;
      if (count != 99) begin errors++; $display("FAIL exhaust_count: got %0d want 99", count); end
      checks++;
      if (b_found !== 1'b0) begin errors++; $display("FAIL exhaust_found: got %b want 0", b_found); end
      checks++;
      if (b_answer !== 7'h7f) begin errors++; $display("FAIL exhaust_answer: got %h want 7f", b_answer); end
   endtask

   initial begin
      a_reset_n = 1'b0; a_start = 1'b0; a_key = '0; a_klen = '0;
      a_ready = 1'b0; a_rv = 1'b0; a_rn = '0;
      b_reset_n = 1'b0; b_start = 1'b0; b_key = '0; b_klen = '0;
      b_ready = 1'b0; b_rv = 1'b0; b_rn = '0;
      test_reset;
      test_search;
      test_best_tracking;
      test_backpressure_and_reset;
      test_exhaust;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
